// File: rtl/seq_multiplier_nbits_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Bits needed to count iterations 0..w-1.
  function automatic int count_width(int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_nbits_if.sv
// Request/result bundle between the control unit (master) and the multiplier (slave).
interface seq_multiplier_nbits_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic             signedMode;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] productHi;
  logic [WIDTH-1:0] productLo;

  modport master (
    output start, signedMode, multiplicand, multiplier,
    input  busy, done, productHi, productLo
  );

  modport slave (
    input  start, signedMode, multiplicand, multiplier,
    output busy, done, productHi, productLo
  );
endinterface

// File: rtl/seq_multiplier_nbits_cond_negate.sv
// Combinational conditional two's-complement negate, N bits wide.
module cond_negate_nbits #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_in,
  input  logic         i_neg,
  output logic [N-1:0] o_out
);
  assign o_out = i_neg ? (~i_in + N'(1)) : i_in;
endmodule

// File: rtl/seq_multiplier_nbits.sv
// Iterative shift-and-add multiplier, one multiplier bit per clock, signed or unsigned.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier_nbits
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clock,
  input  logic                  nReset,
  seq_multiplier_nbits_if.slave bus
);
  localparam int            CW   = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t        r_state, w_state_next;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic               r_neg;
  logic [WIDTH-1:0]   r_prod_hi, r_prod_lo;

  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_mplier_next;
  logic [2*WIDTH-1:0] w_acc_next, w_result;
  logic               w_accept, w_last;

  // Operands are reduced to magnitudes up front; the sign is reapplied to the final product.
  cond_negate_nbits #(.N(WIDTH)) u_mag_a (
    .i_in  (bus.multiplicand),
    .i_neg (bus.signedMode & bus.multiplicand[WIDTH-1]),
    .o_out (w_mag_a)
  );

  cond_negate_nbits #(.N(WIDTH)) u_mag_b (
    .i_in  (bus.multiplier),
    .i_neg (bus.signedMode & bus.multiplier[WIDTH-1]),
    .o_out (w_mag_b)
  );

  cond_negate_nbits #(.N(2*WIDTH)) u_fix_sign (
    .i_in  (w_acc_next),
    .i_neg (r_neg),
    .o_out (w_result)
  );

  assign w_accept = bus.start && (r_state != CALC);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_mplier_next = r_mplier >> 1;
`ifdef MULT_EARLY_EXIT_EN
    w_last        = (r_count == LAST) || (w_mplier_next == '0);
`else
    w_last        = (r_count == LAST);
`endif
    w_state_next  = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = CALC;
      CALC:    if (w_last)    w_state_next = DONE;
      DONE:    w_state_next = bus.start ? CALC : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
        r_mplier <= w_mag_b;
        r_count  <= '0;
        r_neg    <= bus.signedMode & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
      end else if (r_state == CALC) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= w_mplier_next;
        r_count  <= r_count + CW'(1);
        if (w_last) {r_prod_hi, r_prod_lo} <= w_result;
      end
    end
  end

  assign bus.busy      = (r_state == CALC);
  assign bus.done      = (r_state == DONE);
  assign bus.productHi = r_prod_hi;
  assign bus.productLo = r_prod_lo;
endmodule
